// File: rtl/mbd_pkg.sv
// Shared types and helpers for the multi-channel button debouncer.
// Holds the per-channel FSM state enum and the counter-width helper
// used to size every counter in mbd_channel.
package mbd_pkg;

    // Per-channel debounce FSM states.
    typedef enum logic [1:0] {
        ST_STABLE    = 2'd0,
        ST_LOCKOUT   = 2'd1,
        ST_CANDIDATE = 2'd2
    } mbd_state_e;

    // One shared counter width, big enough for the debounce length and
    // for the hold threshold plus one repeat period.
    function automatic int cntWidth(input int debCycles, input int holdCycles, input int repCycles);
        int maxVal;
        maxVal = (debCycles > holdCycles + repCycles) ? debCycles : (holdCycles + repCycles);
        return $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/mbd_channel.sv
// One debounce channel: 2-flop synchronizer, STABLE/LOCKOUT/CANDIDATE FSM,
// edge strobes and a hold/auto-repeat counter.
// Optional feature: define MULTI_BTN_DEBOUNCER_AUTO_REPEAT_EN to emit a
// hold strobe every REPEAT_CYCLES enabled cycles after the first one.
module mbd_channel
    import mbd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20_000,
    parameter int INSTANT_MODE    = 1,
    parameter int HOLD_CYCLES     = 1_000_000,
    parameter int REPEAT_CYCLES   = 250_000
) (
    input  logic i_clk,
    input  logic i_nrst,
    input  logic i_ena,
    input  logic i_sig,
    output logic o_debounced,
    output logic o_press,
    output logic o_release,
    output logic o_hold
);

    localparam int CW = cntWidth(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] C_ZERO    = '0;
    localparam logic [CW-1:0] C_ONE     = CW'(1);
    localparam logic [CW-1:0] C_DEB     = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] C_DEB_M1  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] C_HOLD    = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] C_HOLD_M1 = CW'(HOLD_CYCLES - 1);
`ifdef MULTI_BTN_DEBOUNCER_AUTO_REPEAT_EN
    localparam logic [CW-1:0] C_REP_END = CW'(HOLD_CYCLES + REPEAT_CYCLES - 1);
`endif

    logic          r_sync1;
    logic          r_sync2;
    mbd_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_holdCnt;
    logic          r_debounced;
    logic          r_press;
    logic          r_release;
    logic          r_hold;

    mbd_state_e    w_stateNext;
    logic [CW-1:0] w_cntNext;
    logic [CW-1:0] w_holdNext;
    logic          w_diff;
    logic          w_toggle;
    logic          w_debNext;
    logic          w_press;
    logic          w_release;
    logic          w_holdEvent;

    // Two-flop synchronizer; runs every cycle so ena never stalls sampling.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_sig;
            r_sync2 <= r_sync1;
        end
    end

    assign w_diff = r_sync2 ^ r_debounced;

    // FSM state register; frozen while ena is low.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= ST_STABLE;
        end else if (i_ena) begin
            r_state <= w_stateNext;
        end
    end

    // Next state, debounce counter and toggle decision (counter saturates both ways).
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_toggle    = 1'b0;
        case (r_state)
            ST_STABLE: begin
                if (w_diff) begin
                    if (INSTANT_MODE != 0) begin
                        w_toggle    = 1'b1;
                        w_cntNext   = C_DEB_M1;
                        w_stateNext = ST_LOCKOUT;
                    end else begin
                        w_cntNext   = C_ONE;
                        w_stateNext = ST_CANDIDATE;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (r_cnt == C_ZERO) begin
                    w_stateNext = ST_STABLE;
                end else begin
                    w_cntNext = r_cnt - C_ONE;
                end
            end
            ST_CANDIDATE: begin
                if (!w_diff) begin
                    w_stateNext = ST_STABLE;
                end else if (r_cnt >= C_DEB) begin
                    w_toggle    = 1'b1;
                    w_stateNext = ST_STABLE;
                end else begin
                    w_cntNext = r_cnt + C_ONE;
                end
            end
            default: begin
                w_stateNext = ST_STABLE;
            end
        endcase
    end

    // Edge strobes and hold/repeat counting derived from the toggle decision.
    always_comb begin
        w_debNext   = r_debounced ^ w_toggle;
        w_press     = w_toggle & ~r_debounced;
        w_release   = w_toggle & r_debounced;
        w_holdNext  = r_holdCnt;
        w_holdEvent = 1'b0;
        if (!r_debounced || w_toggle) begin
            w_holdNext = C_ZERO;
        end else if (r_holdCnt < C_HOLD) begin
            w_holdNext  = r_holdCnt + C_ONE;
            w_holdEvent = (r_holdCnt == C_HOLD_M1);
        end
`ifdef MULTI_BTN_DEBOUNCER_AUTO_REPEAT_EN
        else if (r_holdCnt == C_REP_END) begin
            w_holdNext  = C_HOLD;
            w_holdEvent = 1'b1;
        end else begin
            w_holdNext = r_holdCnt + C_ONE;
        end
`endif
    end

    // Datapath registers; everything holds while ena is low so no event is lost.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_cnt       <= C_ZERO;
            r_holdCnt   <= C_ZERO;
            r_debounced <= 1'b0;
            r_press     <= 1'b0;
            r_release   <= 1'b0;
            r_hold      <= 1'b0;
        end else if (i_ena) begin
            r_cnt       <= w_cntNext;
            r_holdCnt   <= w_holdNext;
            r_debounced <= w_debNext;
            r_press     <= w_press;
            r_release   <= w_release;
            r_hold      <= w_holdEvent;
        end
    end

    // A strobe held over a disabled stretch is masked until ena returns.
    assign o_debounced = r_debounced;
    assign o_press     = r_press & i_ena;
    assign o_release   = r_release & i_ena;
    assign o_hold      = r_hold & i_ena;

endmodule

// File: rtl/multi_btn_debouncer.sv
// Multi-channel button debouncer top: parameters plus one mbd_channel per input.
// Optional feature: MULTI_BTN_DEBOUNCER_AUTO_REPEAT_EN enables hold auto-repeat.
module multi_btn_debouncer #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 20_000,
    parameter int INSTANT_MODE    = 1,
    parameter int HOLD_CYCLES     = 1_000_000,
    parameter int REPEAT_CYCLES   = 250_000
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              ena,
    input  logic [NUM_CH-1:0] sig_in,
    output logic [NUM_CH-1:0] sig_debounced,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] hold_pulse
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mbd_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INSTANT_MODE    (INSTANT_MODE),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .i_clk       (clk),
            .i_nrst      (nrst),
            .i_ena       (ena),
            .i_sig       (sig_in[g]),
            .o_debounced (sig_debounced[g]),
            .o_press     (press_pulse[g]),
            .o_release   (release_pulse[g]),
            .o_hold      (hold_pulse[g])
        );
    end

endmodule

// File: tb/tb_multi_btn_debouncer.sv
// Scoreboard bench for multi_btn_debouncer: one instant-mode and one
// filter-mode instance. Stimulus pushes expected strobes (cycle, dut, kind,
// channel); a monitor pops and compares whenever a strobe appears.
module tb_multi_btn_debouncer;

    localparam int NCH    = 4;
    localparam int DEB    = 4;
    localparam int HOLD   = 20;
    localparam int REP    = 8;
    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_HOLD  = 2;

    typedef struct {
        int at;
        int dut;
        int kind;
        int ch;
    } ev_t;

    logic           clk = 1'b0;
    logic           nrst;
    logic           ena;
    logic [NCH-1:0] sigA, sigB;
    logic [NCH-1:0] debA, pressA, relA, holdA;
    logic [NCH-1:0] debB, pressB, relB, holdB;
    logic [NCH-1:0] monP;
    int             cyc = 0;
    int             total = 0;
    int             bad = 0;
    ev_t            expQ[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    multi_btn_debouncer #(
        .NUM_CH(NCH), .DEBOUNCE_CYCLES(DEB), .INSTANT_MODE(1),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dutInst (
        .clk(clk), .nrst(nrst), .ena(ena), .sig_in(sigA),
        .sig_debounced(debA), .press_pulse(pressA),
        .release_pulse(relA), .hold_pulse(holdA)
    );

    multi_btn_debouncer #(
        .NUM_CH(NCH), .DEBOUNCE_CYCLES(DEB), .INSTANT_MODE(0),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dutFilt (
        .clk(clk), .nrst(nrst), .ena(ena), .sig_in(sigB),
        .sig_debounced(debB), .press_pulse(pressB),
        .release_pulse(relB), .hold_pulse(holdB)
    );

    function automatic string kname(input int k);
        if (k == K_PRESS) return "press";
        if (k == K_REL) return "release";
        return "hold";
    endfunction

    function automatic logic [NCH-1:0] pulseOf(input int d, input int k);
        if (d == 0) return (k == K_PRESS) ? pressA : (k == K_REL) ? relA : holdA;
        return (k == K_PRESS) ? pressB : (k == K_REL) ? relB : holdB;
    endfunction

    task automatic expectEv(input int d, input int k, input int c, input int at);
        ev_t e;
        e.at = at; e.dut = d; e.kind = k; e.ch = c;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input int d, input logic [NCH-1:0] v);
        if (d == 0) sigA = v;
        else sigB = v;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkDrained(input string name);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL %s_missing: got %0d pending strobes (first dut=%0d %s ch=%0d at %0d), required 0",
                     name, expQ.size(), expQ[0].dut, kname(expQ[0].kind), expQ[0].ch, expQ[0].at);
        end
        expQ.delete();
    endtask

    task automatic matchEvent(input int d, input int k, input int c);
        int idx = -1;
        for (int i = 0; i < expQ.size(); i++)
            if (idx < 0 && expQ[i].dut == d && expQ[i].kind == k && expQ[i].ch == c) idx = i;
        total++;
        if (idx < 0) begin
            bad++;
            $display("[TB] FAIL unexpected_%s dut=%0d ch=%0d: got strobe at cycle %0d, required none",
                     kname(k), d, c, cyc);
        end else begin
            if (expQ[idx].at != cyc) begin
                bad++;
                $display("[TB] FAIL %s_timing dut=%0d ch=%0d: got cycle %0d, required cycle %0d",
                         kname(k), d, c, cyc, expQ[idx].at);
            end
            expQ.delete(idx);
        end
    endtask

    task automatic waitUntil(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: sample just after each rising edge and reconcile strobes with the queue.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 3; k++) begin
                    monP = pulseOf(d, k);
                    for (int c = 0; c < NCH; c++)
                        if (monP[c]) matchEvent(d, k, c);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion by cycle %0d, required completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        int p;
        nrst = 1'b0;
        ena  = 1'b1;
        sigA = '0;
        sigB = '0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_state_inst", {debA, pressA, relA, holdA}, 0);
        checkOutput("reset_state_filt", {debB, pressB, relB, holdB}, 0);
        nrst = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("post_reset_idle", {debA, debB}, 0);

        // Instant press with glitch, then long hold and release
        $display("[TB] instant press, glitch and hold");
        t0 = cyc;
        p  = t0 + 3;
        applyStimulus(0, 4'b0001);
        expectEv(0, K_PRESS, 0, p);
        expectEv(0, K_HOLD, 0, p + HOLD);
`ifdef MULTI_BTN_DEBOUNCER_AUTO_REPEAT_EN
        for (int r = 1; r <= 4; r++) expectEv(0, K_HOLD, 0, p + HOLD + REP * r);
`endif
        waitUntil(t0 + 2);
        checkOutput("inst_deb_before_latency", debA, 0);
        waitUntil(t0 + 4);
        checkOutput("inst_deb_rise", debA, 4'b0001);
        applyStimulus(0, 4'b0000);
        waitUntil(t0 + 5);
        applyStimulus(0, 4'b0001);
        waitUntil(t0 + 12);
        checkOutput("inst_glitch_ignored", debA, 4'b0001);
        waitUntil(p + 55);
        applyStimulus(0, 4'b0000);
        expectEv(0, K_REL, 0, p + 58);
        waitUntil(p + 64);
        checkOutput("inst_deb_released", debA, 0);
        checkDrained("instant_hold");

        // Filter mode: short pulse rejected, long pulse accepted
        $display("[TB] filter short and long pulses");
        t0 = cyc;
        applyStimulus(1, 4'b0001);
        waitUntil(t0 + 3);
        applyStimulus(1, 4'b0000);
        waitUntil(t0 + 12);
        checkOutput("filt_short_rejected", debB, 0);
        t0 = cyc;
        applyStimulus(1, 4'b0001);
        expectEv(1, K_PRESS, 0, t0 + 7);
        expectEv(1, K_REL, 0, t0 + 12);
        waitUntil(t0 + 5);
        applyStimulus(1, 4'b0000);
        waitUntil(t0 + 6);
        checkOutput("filt_before_latency", debB, 0);
        waitUntil(t0 + 8);
        checkOutput("filt_deb_rise", debB, 4'b0001);
        waitUntil(t0 + 16);
        checkDrained("filter_pulses");

        // ena low for 10 cycles mid-lockout, with a press strobe pending
        $display("[TB] enable freeze during lockout");
        t0 = cyc;
        applyStimulus(0, 4'b0010);
        expectEv(0, K_PRESS, 1, t0 + 3);
        expectEv(0, K_REL, 1, t0 + 18);
        waitUntil(t0 + 3);
        ena = 1'b0;
        applyStimulus(0, 4'b0000);
        waitUntil(t0 + 9);
        checkOutput("freeze_deb_held", debA, 4'b0010);
        checkOutput("freeze_pulses_zero", {pressA, relA, holdA}, 0);
        waitUntil(t0 + 13);
        ena = 1'b1;
        waitUntil(t0 + 17);
        checkOutput("freeze_lockout_extended", debA, 4'b0010);
        waitUntil(t0 + 22);
        checkDrained("freeze_lockout");

        // ena low for 10 cycles mid-hold shifts the hold strobes
        $display("[TB] enable freeze during hold");
        t0 = cyc;
        applyStimulus(0, 4'b0100);
        expectEv(0, K_PRESS, 2, t0 + 3);
        expectEv(0, K_HOLD, 2, t0 + 33);
`ifdef MULTI_BTN_DEBOUNCER_AUTO_REPEAT_EN
        expectEv(0, K_HOLD, 2, t0 + 41);
`endif
        expectEv(0, K_REL, 2, t0 + 43);
        waitUntil(t0 + 10);
        ena = 1'b0;
        waitUntil(t0 + 15);
        checkOutput("hold_freeze_deb", debA, 4'b0100);
        waitUntil(t0 + 20);
        ena = 1'b1;
        waitUntil(t0 + 40);
        applyStimulus(0, 4'b0000);
        waitUntil(t0 + 48);
        checkDrained("freeze_hold");

        // Asynchronous reset mid-lockout with the input still high
        $display("[TB] async reset mid-lockout");
        t0 = cyc;
        applyStimulus(0, 4'b0001);
        expectEv(0, K_PRESS, 0, t0 + 3);
        expectEv(0, K_PRESS, 0, t0 + 8);
        expectEv(0, K_REL, 0, t0 + 14);
        waitUntil(t0 + 3);
        nrst = 1'b0;
        #1;
        checkOutput("async_reset_clears", {debA, pressA, relA, holdA}, 0);
        waitUntil(t0 + 5);
        nrst = 1'b1;
        waitUntil(t0 + 7);
        checkOutput("reset_release_latency", debA, 0);
        waitUntil(t0 + 11);
        applyStimulus(0, 4'b0000);
        waitUntil(t0 + 18);
        checkDrained("reset_mid_lockout");

        // All channels at once, widths 1/2/6/10, both modes
        $display("[TB] simultaneous channels");
        t0 = cyc;
        applyStimulus(0, 4'b1111);
        applyStimulus(1, 4'b1111);
        for (int c = 0; c < NCH; c++) expectEv(0, K_PRESS, c, t0 + 3);
        expectEv(0, K_REL, 0, t0 + 8);
        expectEv(0, K_REL, 1, t0 + 8);
        expectEv(0, K_REL, 2, t0 + 9);
        expectEv(0, K_REL, 3, t0 + 13);
        expectEv(1, K_PRESS, 2, t0 + 7);
        expectEv(1, K_PRESS, 3, t0 + 7);
        expectEv(1, K_REL, 2, t0 + 13);
        expectEv(1, K_REL, 3, t0 + 17);
        waitUntil(t0 + 1);
        applyStimulus(0, 4'b1110);
        applyStimulus(1, 4'b1110);
        waitUntil(t0 + 2);
        applyStimulus(0, 4'b1100);
        applyStimulus(1, 4'b1100);
        waitUntil(t0 + 6);
        applyStimulus(0, 4'b1000);
        applyStimulus(1, 4'b1000);
        waitUntil(t0 + 7);
        checkOutput("multi_inst_levels", debA, 4'b1111);
        checkOutput("multi_filt_levels", debB, 4'b1100);
        waitUntil(t0 + 10);
        applyStimulus(0, 4'b0000);
        applyStimulus(1, 4'b0000);
        waitUntil(t0 + 22);
        checkOutput("multi_final_levels", {debA, debB}, 0);
        checkDrained("multi_channel");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_btn_debouncer.md
MULTI_BTN_DEBOUNCER -- requirements
Module: multi_btn_debouncer

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent input channels (>=1).
REQ-002 Parameter DEBOUNCE_CYCLES, default 20_000, lockout length (instant mode) or required stable length (filter mode), in enabled cycles (>=1).
REQ-003 Parameter INSTANT_MODE, default 1; 1 = instant-edge-then-lockout, 0 = stable-filter.
REQ-004 Parameter HOLD_CYCLES, default 1_000_000, enabled cycles high before first hold event (>=1).
REQ-005 Parameter REPEAT_CYCLES, default 250_000, auto-repeat period in enabled cycles (>=1).
REQ-006 clk  input  1  sole clock; all state changes on rising edge.
REQ-007 nrst  input  1  reset, asynchronous assert, active-low.
REQ-008 ena  input  1  clock enable for debounce/hold state.
REQ-009 sig_in  input  NUM_CH  raw asynchronous channel inputs.
REQ-010 sig_debounced  output  NUM_CH  registered debounced levels.
REQ-011 press_pulse  output  NUM_CH  one-cycle strobe on debounced rise.
REQ-012 release_pulse  output  NUM_CH  one-cycle strobe on debounced fall.
REQ-013 hold_pulse  output  NUM_CH  one-cycle strobe on hold/repeat event.

Function
REQ-014 Each sig_in bit SHALL pass a 2-flop synchronizer (sig_sync), clocked every cycle regardless of ena.
REQ-015 Each channel SHALL run an independent FSM {STABLE, LOCKOUT, CANDIDATE}; no cross-channel interaction.
REQ-016 INSTANT_MODE=1, STABLE: sig_sync != sig_debounced and ena -> sig_debounced toggles next edge, counter <= DEBOUNCE_CYCLES-1, go LOCKOUT (total latency sig_in->sig_debounced = 3 cycles).
REQ-017 LOCKOUT: sig_debounced held; counter decrements per enabled cycle; counter==0 and ena -> STABLE; input changes during LOCKOUT ignored, but a difference still present on return to STABLE is taken the following cycle.
REQ-018 INSTANT_MODE=0, STABLE: sig_sync != sig_debounced and ena -> CANDIDATE, counter <= 1.
REQ-019 CANDIDATE: sig_sync == sig_debounced -> STABLE, no output change; else when counter == DEBOUNCE_CYCLES, toggle sig_debounced and go STABLE, otherwise counter increments (latency 2+DEBOUNCE_CYCLES+1 cycles for a clean step).
REQ-020 press_pulse/release_pulse SHALL assert exactly in the cycle sig_debounced first shows the new level, for one cycle.
REQ-021 Hold counter SHALL count enabled cycles while sig_debounced=1, clear to 0 when sig_debounced=0; hold_pulse asserts in the cycle the count reaches HOLD_CYCLES.
REQ-022 ena=0: FSM, counters, sig_debounced frozen; all pulse outputs forced 0; resumes with no lost or duplicated events.
REQ-023 Counter widths SHALL be $clog2(max(DEBOUNCE_CYCLES,HOLD_CYCLES+REPEAT_CYCLES)+1); counters SHALL saturate, never wrap.

Reset
REQ-024 nrst=0 SHALL asynchronously clear synchronizers, sig_debounced, all pulses and counters to 0 and FSMs to STABLE, including mid-LOCKOUT/CANDIDATE.
REQ-025 Reset deassertion is synchronous to clk by the integrator; the first active edge after release behaves as from STABLE with sig_debounced=0.

Configuration
REQ-026 Macro MULTI_BTN_DEBOUNCER_AUTO_REPEAT_EN defined: after the first hold_pulse, further hold_pulse every REPEAT_CYCLES enabled cycles while sig_debounced stays 1.
REQ-027 Macro undefined: exactly one hold_pulse per press; REPEAT_CYCLES ignored, no repeat logic synthesized.

Structure
REQ-028 Package mbd_pkg SHALL hold the FSM state enum and the counter-width helper function.
REQ-029 Per-channel logic SHALL be sub-module mbd_channel, instantiated NUM_CH times via generate loop; top holds parameters only.

Verification (NUM_CH=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8)
REQ-030 Instant: sig_in[0] 0->1 at cycle 0, 1-cycle glitch to 0 at cycle 4 -> sig_debounced[0]=1 from cycle 3, press_pulse[0] only at cycle 3, no release.
REQ-031 Filter: 3-cycle high pulse -> no change; 5-cycle high pulse -> sig_debounced rises 7 cycles after sig_in edge, press_pulse one cycle.
REQ-032 Hold 60 cycles, macro defined -> hold_pulse at 20, 28, 36, 44, 52 cycles after press_pulse; undefined -> only at 20.
REQ-033 ena=0 for 10 cycles mid-LOCKOUT and mid-hold -> outputs frozen, pulses 0, events shifted exactly 10 cycles.
REQ-034 nrst low mid-LOCKOUT with sig_in=1 -> all outputs 0 immediately (no clock); after release, press_pulse 3 cycles later.
REQ-035 All 4 channels toggled simultaneously with different widths -> each matches its single-channel reference response.
